seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter: DEAD_CYC, default 16, anti-ghosting all-digits-off interval in CLK cycles after each digit change (legal 0..255).
REQ-002 SHALL have port: CLK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: CE  input  1  scan tick (nominally 1 kHz, one CLK wide); advances digit.
REQ-005 SHALL have port: HEX_IN  input  32  eight nibbles; digit i = HEX_IN[4i+3:4i].
REQ-006 SHALL have port: BLANK  input  8  BLANK[i]=1 blanks digit i.
REQ-007 SHALL have port: DP_IN  input  8  DP_IN[i]=1 lights decimal point of digit i.
REQ-008 SHALL have port: DIG_N  output  8  digit anodes, active-low, at most one low.
REQ-009 SHALL have port: SEG_N  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port: DP_N  output  1  decimal point, active-low.
REQ-011 SHALL have port: FRAME_STB  output  1  one-cycle pulse on shadow-register load.

Function
REQ-012 SHALL keep 3-bit digit index IDX; each CE=1 cycle: IDX <= IDX+1, wrapping 7->0.
REQ-013 SHALL, on the CE cycle taking IDX to 0, load HEX_IN, BLANK, DP_IN into shadow registers and assert FRAME_STB the next cycle; display reads shadows only (no mid-frame tearing).
REQ-014 SHALL, on CE at cycle n: DIG_N=8'hFF and SEG_N/DP_N updated to new digit at n+1; DIG_N[IDX]=0 at n+1+DEAD_CYC; DEAD_CYC=0 enables at n+1.
REQ-015 SHALL decode nibbles (SEG_N hex): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,B=03,C=46,D=21,E=06,F=0E.
REQ-016 SHALL, for blanked digit, drive SEG_N=7'h7F and DP_N=1; DIG_N sequencing unchanged.
REQ-017 SHALL drive DP_N=~DP shadow[IDX] when digit not blanked.
REQ-018 SHALL, on CE during dead time, advance IDX and restart dead-time counter from DEAD_CYC.
REQ-019 SHALL, when CE period <= DEAD_CYC, keep DIG_N=8'hFF permanently (no partial enables).
REQ-020 SHALL register all outputs; no combinational input-to-output path.

Reset
REQ-021 SHALL on RST=1 at clock edge: DIG_N=8'hFF, SEG_N=7'h7F, DP_N=1, FRAME_STB=0, IDX=7, dead counter=0, HEX shadow=0, BLANK shadow=8'hFF, DP shadow=0.
REQ-022 SHALL give RST priority over CE in same cycle; first CE after reset takes IDX to 0 and loads shadows.
REQ-023 SHALL abort any dead time or frame on mid-operation reset with no residual enabled digit.

Configuration
REQ-024 SHALL support macro SEG7_LEADING_ZERO_BLANK_EN.
REQ-025 SHALL, with macro defined, compute at shadow load a zero-suppress mask: digits 7 downward with nibble 0 blanked until first nonzero nibble; digit 0 never suppressed; effective blank = BLANK shadow OR mask.
REQ-026 SHALL, without macro, use BLANK shadow only; no mask logic synthesized.

Verification
REQ-027 SHALL test: reset, HEX_IN=32'h76543210, BLANK=0, DEAD_CYC=4, CE every 100 cycles -> DIG_N walks FE,FD..7F; digit 0 SEG_N=40, digit 7 SEG_N=78; each enable 5 cycles after CE.
REQ-028 SHALL test: HEX_IN=32'hFEDCBA98 -> SEG_N 00,10,08,03,46,21,06,0E for digits 0..7; FRAME_STB once per 8 CEs.
REQ-029 SHALL test: HEX_IN changed to 32'h11111111 while IDX=3 -> digits 4..7 keep old values until next IDX=0 load.
REQ-030 SHALL test: BLANK=8'h0F, DP_IN=8'h01 -> digit 0 SEG_N=7F, DP_N=1 with DIG_N[0]=0; digit 4 shows value.
REQ-031 SHALL test: RST pulsed during dead time -> next cycle DIG_N=FF, SEG_N=7F; CE with RST=1 ignored.
REQ-032 SHALL test: macro defined, HEX_IN=32'h00000A05 -> digits 7..3 blanked, digits 2..0 show A,0,5; HEX_IN=0 -> only digit 0 shows 0 (SEG_N=40).

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit seven-segment scan driver with frame shadow registers and anti-ghosting dead time.
// Optional leading-zero suppression is compiled in with `define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int unsigned DEAD_CYC = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic [31:0] HEX_IN,
    input  logic [7:0]  BLANK,
    input  logic [7:0]  DP_IN,
    output logic [7:0]  DIG_N,
    output logic [6:0]  SEG_N,
    output logic        DP_N,
    output logic        FRAME_STB
);

    localparam logic [7:0] DEAD_INIT = 8'(DEAD_CYC);

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [2:0]  idx;
    logic [2:0]  idx_next;
    logic [7:0]  dead_cnt;
    logic [31:0] hex_sh;
    logic [7:0]  blank_sh;
    logic [7:0]  dp_sh;
    logic        load;
    logic [31:0] hex_eff;
    logic [7:0]  blank_eff;
    logic [7:0]  dp_eff;
    logic [7:0]  blank_cur;
    logic [3:0]  nib_new;
    logic        blank_new;
    logic        dp_new;

    // The digit being entered on a loading CE must already see the new frame.
    assign load      = CE && (idx == 3'd7);
    assign idx_next  = idx + 3'd1;
    assign hex_eff   = load ? HEX_IN : hex_sh;
    assign blank_eff = load ? BLANK  : blank_sh;
    assign dp_eff    = load ? DP_IN  : dp_sh;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [7:0] zmask_in;
    logic [7:0] zmask_sh;
    logic       zero_run;

    always_comb begin
        zmask_in = 8'h00;
        zero_run = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (HEX_IN[4*i +: 4] != 4'h0) zero_run = 1'b0;
            zmask_in[i] = zero_run;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)       zmask_sh <= 8'h00;
        else if (load) zmask_sh <= zmask_in;
    end

    assign blank_cur = blank_eff | (load ? zmask_in : zmask_sh);
`else
    assign blank_cur = blank_eff;
`endif

    assign nib_new   = hex_eff[{idx_next, 2'b00} +: 4];
    assign blank_new = blank_cur[idx_next];
    assign dp_new    = dp_eff[idx_next];

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx       <= 3'd7;
            dead_cnt  <= 8'd0;
            hex_sh    <= 32'h0;
            blank_sh  <= 8'hFF;
            dp_sh     <= 8'h00;
            DIG_N     <= 8'hFF;
            SEG_N     <= 7'h7F;
            DP_N      <= 1'b1;
            FRAME_STB <= 1'b0;
        end else begin
            FRAME_STB <= load;
            if (load) begin
                hex_sh   <= HEX_IN;
                blank_sh <= BLANK;
                dp_sh    <= DP_IN;
            end
            if (CE) begin
                idx   <= idx_next;
                SEG_N <= blank_new ? 7'h7F : decode(nib_new);
                DP_N  <= blank_new ? 1'b1 : ~dp_new;
                if (DEAD_INIT == 8'd0) begin
                    DIG_N    <= ~(8'd1 << idx_next);
                    dead_cnt <= 8'd0;
                end else begin
                    DIG_N    <= 8'hFF;
                    dead_cnt <= DEAD_INIT;
                end
            end else if (dead_cnt == 8'd1) begin
                // Only the 1->0 transition enables, so an idle zero count after reset stays dark.
                dead_cnt <= 8'd0;
                DIG_N    <= ~(8'd1 << idx);
            end else if (dead_cnt != 8'd0) begin
                dead_cnt <= dead_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DEAD_CYC=4; leading-zero checks follow SEG7_LEADING_ZERO_BLANK_EN.
module tb_seg7_scan_driver;

    logic        CLK;
    logic        RST;
    logic        CE;
    logic [31:0] HEX_IN;
    logic [7:0]  BLANK;
    logic [7:0]  DP_IN;
    logic [7:0]  DIG_N;
    logic [6:0]  SEG_N;
    logic        DP_N;
    logic        FRAME_STB;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_driver #(.DEAD_CYC(4)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .HEX_IN(HEX_IN), .BLANK(BLANK), .DP_IN(DP_IN),
        .DIG_N(DIG_N), .SEG_N(SEG_N), .DP_N(DP_N), .FRAME_STB(FRAME_STB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Returns in the cycle right after the CE cycle.
    task automatic pulse_ce();
        CE = 1'b1;
        @(negedge CLK);
        CE = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scan_digit(input int k, input logic [6:0] exp_seg, input logic exp_dp,
                              input logic exp_frame, input int period);
        logic [7:0] exp_dig;
        exp_dig = ~(8'd1 << k);
        pulse_ce();
        check($sformatf("seg_d%0d", k), {1'b0, SEG_N}, {1'b0, exp_seg});
        check($sformatf("dp_d%0d", k), {7'b0, DP_N}, {7'b0, exp_dp});
        check($sformatf("dig_off_d%0d", k), DIG_N, 8'hFF);
        check($sformatf("frame_d%0d", k), {7'b0, FRAME_STB}, {7'b0, exp_frame});
        cyc(3);
        check($sformatf("dig_dead_d%0d", k), DIG_N, 8'hFF);
        cyc(1);
        check($sformatf("dig_on_d%0d", k), DIG_N, exp_dig);
        cyc(period - 5);
    endtask

    initial begin
        RST = 1'b1; CE = 1'b0; HEX_IN = 32'h0; BLANK = 8'h00; DP_IN = 8'h00;
        cyc(2);
        check("rst_dig", DIG_N, 8'hFF);
        check("rst_seg", {1'b0, SEG_N}, 8'h7F);
        check("rst_dp", {7'b0, DP_N}, 8'h01);
        check("rst_frame", {7'b0, FRAME_STB}, 8'h00);
        // CE while in reset must be ignored.
        CE = 1'b1;
        cyc(1);
        CE = 1'b0; RST = 1'b0;
        cyc(3);
        check("post_rst_dig", DIG_N, 8'hFF);
        check("post_rst_seg", {1'b0, SEG_N}, 8'h7F);

        HEX_IN = 32'h76543210; BLANK = 8'h00; DP_IN = 8'h00;
        for (int k = 0; k < 8; k++) scan_digit(k, seg_tab[k], 1'b1, k == 0, 100);

        HEX_IN = 32'hFEDCBA98;
        for (int k = 0; k < 8; k++) scan_digit(k, seg_tab[8 + k], 1'b1, k == 0, 20);

        // Input change mid-frame must not show until the next frame load.
        for (int k = 0; k < 4; k++) scan_digit(k, seg_tab[8 + k], 1'b1, k == 0, 20);
        HEX_IN = 32'h11111111;
        for (int k = 4; k < 8; k++) scan_digit(k, seg_tab[8 + k], 1'b1, 1'b0, 20);
        scan_digit(0, seg_tab[1], 1'b1, 1'b1, 20);

        HEX_IN = 32'h76543210; BLANK = 8'h0F; DP_IN = 8'h01;
        for (int k = 1; k < 8; k++) scan_digit(k, seg_tab[1], 1'b1, 1'b0, 20);
        for (int k = 0; k < 8; k++) scan_digit(k, (k < 4) ? 7'h7F : seg_tab[k], 1'b1, k == 0, 20);

        BLANK = 8'h00; DP_IN = 8'h01;
        for (int k = 0; k < 8; k++) scan_digit(k, seg_tab[k], (k == 0) ? 1'b0 : 1'b1, k == 0, 20);

        // CE period equal to the dead time: no digit may ever light.
        for (int i = 0; i < 10; i++) begin
            pulse_ce();
            cyc(3);
            check($sformatf("fast_ce_dig_%0d", i), DIG_N, 8'hFF);
        end
        cyc(1);
        check("fast_ce_end_dig", DIG_N, 8'hFD);
        check("fast_ce_end_seg", {1'b0, SEG_N}, {1'b0, seg_tab[1]});

        // Reset during dead time, with a simultaneous CE.
        pulse_ce();
        cyc(1);
        RST = 1'b1; CE = 1'b1;
        cyc(1);
        RST = 1'b0; CE = 1'b0;
        check("mid_rst_dig", DIG_N, 8'hFF);
        check("mid_rst_seg", {1'b0, SEG_N}, 8'h7F);
        check("mid_rst_dp", {7'b0, DP_N}, 8'h01);
        check("mid_rst_frame", {7'b0, FRAME_STB}, 8'h00);
        cyc(8);
        check("mid_rst_idle_dig", DIG_N, 8'hFF);
        DP_IN = 8'h00;
        scan_digit(0, seg_tab[0], 1'b1, 1'b1, 20);

        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        HEX_IN = 32'h00000A05; BLANK = 8'h00; DP_IN = 8'h00;
        scan_digit(0, seg_tab[5], 1'b1, 1'b1, 20);
        scan_digit(1, seg_tab[0], 1'b1, 1'b0, 20);
        scan_digit(2, seg_tab[10], 1'b1, 1'b0, 20);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        for (int k = 3; k < 8; k++) scan_digit(k, 7'h7F, 1'b1, 1'b0, 20);
        HEX_IN = 32'h0;
        scan_digit(0, seg_tab[0], 1'b1, 1'b1, 20);
        for (int k = 1; k < 8; k++) scan_digit(k, 7'h7F, 1'b1, 1'b0, 20);
`else
        for (int k = 3; k < 8; k++) scan_digit(k, seg_tab[0], 1'b1, 1'b0, 20);
        HEX_IN = 32'h0;
        for (int k = 0; k < 8; k++) scan_digit(k, seg_tab[0], 1'b1, k == 0, 20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
